// File: rtl/lockstep_checker_if.sv
// Signal bundle between the redundant core pair, the lockstep comparator and the status peripheral.
// The master modport is the stimulus/peripheral side; the slave modport is the comparator itself.
interface lockstep_checker_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  enable_i;
  logic                  clear_i;
  logic                  master_valid_i;
  logic [DATA_WIDTH-1:0] master_sig_i;
  logic                  shadow_valid_i;
  logic [DATA_WIDTH-1:0] shadow_sig_i;
  logic                  mismatch_o;
  logic                  error_o;
  logic [CNT_WIDTH-1:0]  err_cnt_o;
  logic [DATA_WIDTH-1:0] first_master_o;
  logic [DATA_WIDTH-1:0] first_shadow_o;
  logic                  armed_o;

  modport master (
    output enable_i, clear_i, master_valid_i, master_sig_i, shadow_valid_i, shadow_sig_i,
    input  mismatch_o, error_o, err_cnt_o, first_master_o, first_shadow_o, armed_o
  );

  modport slave (
    input  enable_i, clear_i, master_valid_i, master_sig_i, shadow_valid_i, shadow_sig_i,
    output mismatch_o, error_o, err_cnt_o, first_master_o, first_shadow_o, armed_o
  );
endinterface

// File: rtl/lockstep_checker.sv
// Delayed-lockstep comparator: delays the master signature by DELAY cycles, compares it with the
// shadow core and keeps a sticky error flag, a saturating mismatch count and a first-failure snapshot.
module lockstep_checker #(
  parameter int DATA_WIDTH = 32,
  parameter int DELAY      = 2,
  parameter int CNT_WIDTH  = 16
) (
  input logic              clk_i,
  input logic              rst_ni,
  lockstep_checker_if.slave bus
);
  localparam int                   WARM_W   = $clog2(DELAY + 1);
  localparam logic [WARM_W-1:0]    WARM_MAX = WARM_W'(DELAY);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  logic [DELAY-1:0]      pipe_valid;
  logic [DATA_WIDTH-1:0] pipe_sig [DELAY];
  logic [WARM_W-1:0]     warm_cnt;
  logic                  dm_valid;
  logic [DATA_WIDTH-1:0] dm_sig;
  logic                  armed;
  logic                  mismatch_now;
  logic                  mismatch_q;
  logic                  error_q;
  logic [CNT_WIDTH-1:0]  err_cnt_q;
  logic [DATA_WIDTH-1:0] first_master_q;
  logic [DATA_WIDTH-1:0] first_shadow_q;

  // The delay line runs freely, independent of enable, so it is already full of live data when armed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_valid <= '0;
      for (int i = 0; i < DELAY; i++) pipe_sig[i] <= '0;
    end else begin
      pipe_valid[0] <= bus.master_valid_i;
      pipe_sig[0]   <= bus.master_sig_i;
      for (int i = 1; i < DELAY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_sig[i]   <= pipe_sig[i-1];
      end
    end
  end

  // Warm-up keeps stale pipe contents from being compared right after enable rises.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      warm_cnt <= '0;
    end else if (!bus.enable_i) begin
      warm_cnt <= '0;
    end else if (warm_cnt != WARM_MAX) begin
      warm_cnt <= warm_cnt + 1'b1;
    end
  end

  assign dm_valid = pipe_valid[DELAY-1];
  assign dm_sig   = pipe_sig[DELAY-1];
  assign armed    = bus.enable_i && (warm_cnt == WARM_MAX);

  // Signatures only matter when both sides claim a valid sample.
  always_comb begin
    mismatch_now = 1'b0;
    if (armed) begin
      if (dm_valid != bus.shadow_valid_i) begin
        mismatch_now = 1'b1;
      end else if (dm_valid && bus.shadow_valid_i && (dm_sig != bus.shadow_sig_i)) begin
        mismatch_now = 1'b1;
      end
    end
  end

  // Clear wins over a same-cycle mismatch for the status registers, but the pulse still fires.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mismatch_q     <= 1'b0;
      error_q        <= 1'b0;
      err_cnt_q      <= '0;
      first_master_q <= '0;
      first_shadow_q <= '0;
    end else begin
      mismatch_q <= mismatch_now;
      if (bus.clear_i) begin
        error_q        <= 1'b0;
        err_cnt_q      <= '0;
        first_master_q <= '0;
        first_shadow_q <= '0;
      end else if (mismatch_now) begin
        error_q <= 1'b1;
        if (err_cnt_q != CNT_MAX) err_cnt_q <= err_cnt_q + 1'b1;
        if (!error_q) begin
          first_master_q <= dm_sig;
          first_shadow_q <= bus.shadow_sig_i;
        end
      end
    end
  end

  assign bus.mismatch_o     = mismatch_q;
  assign bus.error_o        = error_q;
  assign bus.err_cnt_o      = err_cnt_q;
  assign bus.first_master_o = first_master_q;
  assign bus.first_shadow_o = first_shadow_q;
  assign bus.armed_o        = armed;
endmodule

// File: tb/tb_lockstep_checker.sv
// Directed bench for lockstep_checker with DELAY=2: one instance with a 16-bit counter and a
// second with a 2-bit counter, both fed the same stream so saturation can be observed.
module tb_lockstep_checker;
  localparam int DW = 32;

  logic clk_i;
  logic rst_ni;
  int   assertCount;
  int   failCount;

  lockstep_checker_if #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) bus ();
  lockstep_checker_if #(.DATA_WIDTH(DW), .CNT_WIDTH(2))  busSat ();

  lockstep_checker #(.DATA_WIDTH(DW), .DELAY(2), .CNT_WIDTH(16)) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  lockstep_checker #(.DATA_WIDTH(DW), .DELAY(2), .CNT_WIDTH(2)) dutSat (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (busSat)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs on both instances, then returns just after the closing edge.
  task automatic applyStimulus(input logic en, input logic clr, input logic mv, input logic [31:0] ms,
                               input logic sv, input logic [31:0] ss);
    bus.enable_i          = en;
    bus.clear_i           = clr;
    bus.master_valid_i    = mv;
    bus.master_sig_i      = ms;
    bus.shadow_valid_i    = sv;
    bus.shadow_sig_i      = ss;
    busSat.enable_i       = en;
    busSat.clear_i        = clr;
    busSat.master_valid_i = mv;
    busSat.master_sig_i   = ms;
    busSat.shadow_valid_i = sv;
    busSat.shadow_sig_i   = ss;
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkStatus(input string tag, input logic mm, input logic err, input logic [15:0] cnt,
                             input logic [31:0] fm, input logic [31:0] fs);
    checkOutput({tag, ".mismatch"}, 32'(bus.mismatch_o), 32'(mm));
    checkOutput({tag, ".error"}, 32'(bus.error_o), 32'(err));
    checkOutput({tag, ".err_cnt"}, 32'(bus.err_cnt_o), 32'(cnt));
    checkOutput({tag, ".first_master"}, bus.first_master_o, fm);
    checkOutput({tag, ".first_shadow"}, bus.first_shadow_o, fs);
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    rst_ni      = 1'b0;
    bus.enable_i = 0; bus.clear_i = 0; bus.master_valid_i = 0; bus.master_sig_i = 0;
    bus.shadow_valid_i = 0; bus.shadow_sig_i = 0;
    busSat.enable_i = 0; busSat.clear_i = 0; busSat.master_valid_i = 0; busSat.master_sig_i = 0;
    busSat.shadow_valid_i = 0; busSat.shadow_sig_i = 0;
    #12;
    checkStatus("reset", 0, 0, 0, 0, 0);
    checkOutput("reset.armed", 32'(bus.armed_o), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Clean stream: shadow repeats the master two cycles later
    applyStimulus(1, 0, 1, 32'h10, 0, 0);
    checkOutput("warm.armed_c0", 32'(bus.armed_o), 0);
    applyStimulus(1, 0, 1, 32'h11, 0, 0);
    checkOutput("warm.armed_c1", 32'(bus.armed_o), 1);
    applyStimulus(1, 0, 1, 32'h12, 1, 32'h10);
    applyStimulus(1, 0, 1, 32'h13, 1, 32'h11);
    applyStimulus(1, 0, 1, 32'h14, 1, 32'h12);
    checkStatus("clean", 0, 0, 0, 0, 0);

    // Two corruptions back to back: first capture must stick
    applyStimulus(1, 0, 1, 32'h10, 1, 32'h13);
    applyStimulus(1, 0, 1, 32'h11, 1, 32'h14);
    applyStimulus(1, 0, 1, 32'h12, 1, 32'h10);
    checkOutput("pre_corrupt.mismatch", 32'(bus.mismatch_o), 0);
    applyStimulus(1, 0, 1, 32'h13, 1, 32'h91);
    checkStatus("corrupt1", 1, 1, 1, 32'h11, 32'h91);
    applyStimulus(1, 0, 1, 32'h30, 1, 32'h00);
    checkStatus("corrupt2", 1, 1, 2, 32'h11, 32'h91);
    applyStimulus(1, 0, 1, 32'h31, 1, 32'h13);
    checkStatus("after_corrupt", 0, 1, 2, 32'h11, 32'h91);

    // Valid disagreement counts; both-invalid with differing sigs does not
    applyStimulus(1, 0, 1, 32'h32, 1, 32'h30);
    applyStimulus(1, 0, 1, 32'h33, 1, 32'h31);
    applyStimulus(1, 0, 0, 32'hAA, 0, 32'h32);
    checkStatus("valid_miss", 1, 1, 3, 32'h11, 32'h91);
    applyStimulus(1, 0, 0, 32'hBB, 1, 32'h33);
    checkOutput("valid_ok.mismatch", 32'(bus.mismatch_o), 0);
    applyStimulus(1, 0, 1, 32'h40, 0, 32'h55);
    checkStatus("both_invalid", 0, 1, 3, 32'h11, 32'h91);
    applyStimulus(1, 0, 1, 32'h41, 0, 32'h66);
    checkOutput("both_invalid2.mismatch", 32'(bus.mismatch_o), 0);

    // Clear coinciding with a mismatch, then a fresh first capture
    applyStimulus(1, 0, 1, 32'h42, 1, 32'h40);
    applyStimulus(1, 1, 1, 32'h43, 1, 32'hFF);
    checkStatus("clear_mm", 1, 0, 0, 0, 0);
    checkOutput("clear_mm.sat_cnt", 32'(busSat.err_cnt_o), 0);
    applyStimulus(1, 0, 1, 32'h44, 1, 32'h42);
    checkStatus("post_clear", 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 32'h45, 1, 32'h99);
    checkStatus("fresh_capture", 1, 1, 1, 32'h43, 32'h99);

    // Six consecutive mismatches: the 2-bit counter pins at 3
    applyStimulus(1, 0, 1, 32'h46, 1, 32'hEE);
    applyStimulus(1, 0, 1, 32'h47, 1, 32'hEE);
    checkOutput("sat.sat_cnt_c2", 32'(busSat.err_cnt_o), 3);
    applyStimulus(1, 0, 1, 32'h48, 1, 32'hEE);
    applyStimulus(1, 0, 1, 32'h49, 1, 32'hEE);
    applyStimulus(1, 0, 1, 32'h4A, 1, 32'hEE);
    checkOutput("sat.consecutive_mm", 32'(bus.mismatch_o), 1);
    applyStimulus(1, 0, 1, 32'h4B, 1, 32'hEE);
    checkOutput("sat.sat_cnt_c6", 32'(busSat.err_cnt_o), 3);
    checkOutput("sat.sat_error", 32'(busSat.error_o), 1);
    checkStatus("sat.wide", 1, 1, 7, 32'h43, 32'h99);

    // Enable drop: no compares while re-warming, garbage shadow ignored
    applyStimulus(0, 0, 1, 32'h4C, 1, 32'hEE);
    checkOutput("disable.armed", 32'(bus.armed_o), 0);
    checkStatus("disable", 0, 1, 7, 32'h43, 32'h99);
    applyStimulus(1, 0, 1, 32'h4D, 1, 32'h77);
    checkOutput("rewarm1.armed", 32'(bus.armed_o), 0);
    checkOutput("rewarm1.mismatch", 32'(bus.mismatch_o), 0);
    applyStimulus(1, 0, 1, 32'h4E, 0, 32'h77);
    checkOutput("rewarm2.armed", 32'(bus.armed_o), 1);
    checkOutput("rewarm2.mismatch", 32'(bus.mismatch_o), 0);
    applyStimulus(1, 0, 1, 32'h4F, 1, 32'h4D);
    checkStatus("rewarm3", 0, 1, 7, 32'h43, 32'h99);

    // Asynchronous reset mid-cycle clears everything at once
    bus.shadow_sig_i = 32'h1234;
    busSat.shadow_sig_i = 32'h1234;
    #2;
    rst_ni = 1'b0;
    #1;
    checkStatus("async_rst", 0, 0, 0, 0, 0);
    checkOutput("async_rst.armed", 32'(bus.armed_o), 0);
    checkOutput("async_rst.sat_cnt", 32'(busSat.err_cnt_o), 0);
    #1;
    rst_ni = 1'b1;
    applyStimulus(1, 0, 1, 32'h60, 0, 0);
    checkOutput("post_rst1.armed", 32'(bus.armed_o), 0);
    applyStimulus(1, 0, 1, 32'h61, 0, 0);
    checkOutput("post_rst2.armed", 32'(bus.armed_o), 1);
    checkStatus("post_rst2", 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule

// File: doc/lockstep_checker.md
# lockstep_checker

Delayed-lockstep comparator for the cluster's redundant core pair. Sits directly upstream of the cluster lockstep peripheral and produces the mismatch events, error count and first-failure capture that the peripheral exposes to software. The master core's output signature is delayed by a fixed number of cycles and compared against the shadow core's signature each cycle. The block holds a sticky error flag, a saturating mismatch counter and a snapshot of the first mismatching pair.

## Interface

Parameters:
- DATA_WIDTH, 32, width of the compared signature (e.g. packed addr/wdata/req).
- DELAY, 2, cycles the shadow core lags the master; legal range 1..8.
- CNT_WIDTH, 16, width of the mismatch counter.

Ports:
- clk_i  in  1  cluster clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- enable_i  in  1  comparison enable (level).
- clear_i  in  1  one-cycle pulse: clear sticky flag, counter and capture registers.
- master_valid_i  in  1  master signature valid this cycle.
- master_sig_i  in  DATA_WIDTH  master signature.
- shadow_valid_i  in  1  shadow signature valid this cycle.
- shadow_sig_i  in  DATA_WIDTH  shadow signature.
- mismatch_o  out  1  one-cycle pulse per detected mismatch.
- error_o  out  1  sticky error flag.
- err_cnt_o  out  CNT_WIDTH  saturating mismatch count.
- first_master_o  out  DATA_WIDTH  delayed master signature at the first mismatch.
- first_shadow_o  out  DATA_WIDTH  shadow signature at the first mismatch.
- armed_o  out  1  warm-up complete; comparisons are active.

## Operation

- Delay line: DELAY stages of {valid, sig}. Stage 0 loads the master inputs every cycle, regardless of enable_i. The last stage is the compare operand (dm_valid, dm_sig).
- Warm-up: a counter loads 0 when enable_i=0. While enable_i=1 it increments to DELAY and then holds. armed_o=1 iff enable_i=1 and count==DELAY. This prevents stale pipe contents from flagging.
- Compare, evaluated only when armed_o=1. A mismatch is either of:
  - dm_valid != shadow_valid_i, or
  - dm_valid & shadow_valid_i & (dm_sig != shadow_sig_i).
  - Signatures are ignored when both valids are 0.
- On a mismatch, at the next edge:
  - mismatch_o=1 for one cycle.
  - err_cnt_o increments, saturating at 2^CNT_WIDTH-1.
  - error_o is set.
  - If error_o was 0 before that edge, first_master_o and first_shadow_o capture the compared values. Otherwise they hold.
- clear_i has priority over a same-cycle mismatch:
  - err_cnt_o, error_o and the captures go to 0.
  - That mismatch is not counted or captured, but mismatch_o still pulses.
- clear_i does not flush the delay line and does not reset warm-up.
- Dropping enable_i mid-stream suppresses compares from the same cycle. Status registers hold their values.

## Timing

- Reset values: mismatch_o=0, error_o=0, err_cnt_o=0, first_master_o=0, first_shadow_o=0, armed_o=0. Delay line valids=0, warm-up count=0.
- Compare path:
  - Master sample at cycle t is compared with the shadow sample at cycle t+DELAY.
  - mismatch_o, err_cnt_o, error_o and the captures update at the edge ending cycle t+DELAY (visible in cycle t+DELAY+1).
- armed_o rises DELAY cycles after enable_i is first sampled high. It falls combinationally with enable_i.
- All outputs except armed_o are registered.
- Back-to-back mismatches produce mismatch_o high on consecutive cycles and +1 per cycle. The count stays at max once saturated.
- Asynchronous reset mid-stream clears all state immediately. After release, warm-up restarts.

## Test plan

- DELAY=2, enable held high, master stream 0x10,0x11,0x12 fed to shadow 2 cycles later -> armed_o rises after 2 cycles; mismatch_o never asserts; err_cnt_o=0.
- Same stream, shadow value at 0x11 corrupted to 0x91 -> one mismatch_o pulse at t+3; err_cnt_o=1; error_o=1; first_master_o=0x11; first_shadow_o=0x91.
- Second corruption 0x12->0x00 after the first -> err_cnt_o=2; captures still 0x11/0x91.
- Shadow valid missing for one cycle while master valid=1 -> mismatch counted. Separately, both valids 0 with differing sigs -> no mismatch.
- clear_i asserted in the same cycle as a mismatch -> mismatch_o pulses, err_cnt_o=0, error_o=0. The next mismatch captures fresh values and gives count 1.
- Saturation with CNT_WIDTH=2, six consecutive mismatches -> err_cnt_o stays at 3.
- enable_i dropped then raised -> no compares for 2 cycles, and a garbage pipe produces no flags.
- rst_ni pulsed mid-stream -> all outputs 0 immediately.
